// File: rtl/uart_rx_core.sv
// UART receiver, 8N1 LSB-first into a one-byte holding register; even parity when UART_RX_PARITY_EN is defined.
// Latency: rx_valid rises one clk after the stop-bit mid-sample, plus 2 clk of line synchronizer.
// No backpressure: a byte arriving while rx_valid=1 is dropped and flagged as overrun.
module uart_rx_core #(
  parameter int DIV_W   = 16,
  parameter int DATA_W  = 8,
  parameter int MIN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              rx_en,
  input  logic              rx,
  input  logic              re,
  input  logic              err_clr,
  output logic [DATA_W-1:0] read_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HI
  } state_t;

  state_t              state_q, state_d;
  logic                rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                commit, ferr_set, ovr_set, perr_set;
  logic                fall, bit_end;

  assign fall    = rx_prev_q & ~rx_s2_q;
  assign bit_end = (cnt_q == baud_div - DIV_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    commit   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    // Disabling mid-frame silently abandons the partial byte.
    if (!rx_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (fall && (baud_div >= DIV_W'(MIN_DIV))) state_d = S_START;
        end
        S_START: begin
          if (cnt_q == (baud_div >> 1)) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_d   = '0;
            shift_d = {rx_s2_q, shift_q[DATA_W-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_d    = '0;
            perr_set = rx_s2_q ^ (^shift_q);
            state_d  = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_d = '0;
            if (rx_s2_q) begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_d  = S_WAIT_HI;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A held-low break must not look like a fresh start bit.
        S_WAIT_HI: begin
          if (rx_s2_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (commit) begin
      if (valid_q && !re) begin
        ovr_set = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (re) begin
      valid_d = 1'b0;
    end
    ferr_d = (ferr_q & ~err_clr) | ferr_set;
    ovr_d  = (ovr_q & ~err_clr) | ovr_set;
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perr_q <= 1'b0;
    else      perr_q <= (perr_q & ~err_clr) | perr_set;
  end
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_set;
`endif

  assign read_data = data_q;
  assign rx_valid  = valid_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized and directed frames for uart_rx_core, scored against a frame-level model of the holding register and flags.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_en, rx, re, err_clr;
  logic [7:0]  read_data;
  logic        rx_valid, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  always #5 clk = ~clk;

  uart_rx_core dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx_en(rx_en), .rx(rx), .re(re),
    .err_clr(err_clr), .read_data(read_data), .rx_valid(rx_valid), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit       exp_valid, exp_ovr, exp_ferr, exp_perr;
  bit [7:0] exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input bit [7:0] d, input bit par, input bit stop);
    rx = 1'b0;
    tick(baud_div);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(baud_div);
    end
    if (PB != 0) begin
      rx = par;
      tick(baud_div);
    end
    rx = stop;
    tick(baud_div);
    rx = 1'b1;
  endtask

  // Frame-level outcome: what the holding register and sticky flags must show once a frame is over.
  task automatic model_frame(input bit [7:0] d, input bit par, input bit stop);
    if (PB != 0 && par != ^d) exp_perr = 1'b1;
    if (!stop) exp_ferr = 1'b1;
    else if (exp_valid) exp_ovr = 1'b1;
    else begin
      exp_valid = 1'b1;
      exp_data  = d;
    end
  endtask

  task automatic send(input bit [7:0] d, input bit par, input bit stop, input int gap);
    drive_frame(d, par, stop);
    model_frame(d, par, stop);
    if (gap > 0) tick(gap);
  endtask

  task automatic read_pulse();
    re = 1'b1;
    tick(1);
    re = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    exp_perr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_vld"}, rx_valid, exp_valid);
    check({tag, "_dat"}, read_data, exp_data);
    check({tag, "_ovr"}, overrun, exp_ovr);
    check({tag, "_ferr"}, frame_err, exp_ferr);
    check({tag, "_busy"}, busy, 1'b0);
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"}, parity_err, exp_perr);
`endif
  endtask

  initial begin
    int       lat, exp_lat, commit_at;
    bit       seen_busy;
    bit [7:0] d;
    bit       stop, par;

    rst = 1'b0; baud_div = 16'd16; rx_en = 1'b1; rx = 1'b1; re = 1'b0; err_clr = 1'b0;
    exp_valid = 0; exp_ovr = 0; exp_ferr = 0; exp_perr = 0; exp_data = 8'h00;
    tick(3);
    check_state("reset");
    rst = 1'b1;
    tick(4);

    // Basic frame and latency from the start edge.
    d = 8'h69;
    exp_lat = 10 * 16 - 8 + 3 + PB * 16;
    fork
      drive_frame(d, ^d, 1'b1);
      begin
        lat = 0;
        while (!rx_valid && lat < 1000) begin
          tick(1);
          lat++;
        end
      end
    join
    check("latency_ok", (lat >= exp_lat - 3 && lat <= exp_lat + 3), 1'b1);
    model_frame(d, ^d, 1'b1);
    tick(4);
    check_state("basic");
    read_pulse();
    check_state("basic_read");

    // Short glitch, then a frame with a bad stop bit.
    rx = 1'b0; tick(4); rx = 1'b1; tick(48);
    check_state("glitch");
    d = 8'hB4;
    send(d, ^d, 1'b0, 8);
    check_state("ferr");
    clear_err();
    check_state("ferr_clr");

    // Long break: one framing error, no retrigger while held low.
    rx = 1'b0;
    tick(12 * 16);
    check("brk_busy", busy, 1'b1);
    exp_ferr = 1'b1;
    rx = 1'b1;
    tick(8);
    check_state("brk");

    // Low for three bit times reads as one frame of 0xFC.
    rx = 1'b0; tick(3 * 16); rx = 1'b1; tick((7 + PB) * 16 + 8);
    model_frame(8'hFC, 1'b1, 1'b1);
    check_state("low3");
    read_pulse();
    clear_err();
    check_state("clr");

    // Back-to-back frames without a read: overrun keeps the old byte.
    d = 8'h11; send(d, ^d, 1'b1, 0);
    d = 8'h22; send(d, ^d, 1'b1, 8);
    check_state("ovr");
    read_pulse();
    clear_err();

    // Read strobe landing on the commit cycle of the second frame.
    d = 8'h11; send(d, ^d, 1'b1, 0);
    commit_at = 4 + 16 / 2 + (9 + PB) * 16;
    d = 8'h22;
    fork
      drive_frame(d, ^d, 1'b1);
      begin
        tick(commit_at - 1);
        re = 1'b1;
        tick(1);
        re = 1'b0;
      end
    join
    exp_valid = 1'b0;
    model_frame(d, ^d, 1'b1);
    tick(8);
    check_state("ovr_re");

    // rx_en dropped after three data bits; holding register untouched.
    d = 8'h5A;
    rx = 1'b0; tick(16);
    for (int i = 0; i < 3; i++) begin rx = d[i]; tick(16); end
    rx_en = 1'b0;
    tick(2);
    check("en_busy", busy, 1'b0);
    for (int i = 3; i < 8 + PB; i++) begin rx = (i < 8) ? d[i] : 1'b0; tick(16); end
    rx = 1'b1; tick(16 + 8);
    rx_en = 1'b1;
    tick(4);
    check_state("en_off");
    read_pulse();

    // Divisor below the legal minimum.
    baud_div = 16'd3;
    tick(4);
    seen_busy = 1'b0;
    d = 8'h00;
    fork
      drive_frame(d, ^d, 1'b1);
      for (int i = 0; i < 40; i++) begin
        seen_busy |= busy;
        tick(1);
      end
    join
    tick(8);
    check("div3_busy", seen_busy, 1'b0);
    check_state("div3");

    // 9600 baud at 20 MHz.
    baud_div = 16'd2083;
    d = 8'hA5;
    send(d, ^d, 1'b1, 8);
    check_state("div2083");
    read_pulse();
    baud_div = 16'd16;

`ifdef UART_RX_PARITY_EN
    d = 8'h69;
    send(d, 1'b0, 1'b1, 8);
    check_state("par_good");
    read_pulse();
    send(d, 1'b1, 1'b1, 8);
    check_state("par_bad");
    read_pulse();
    clear_err();
`endif

    // Randomized frames, reads and error clears.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       baud_div = 16'd8;
        1:       baud_div = 16'd11;
        2:       baud_div = 16'd16;
        default: baud_div = 16'd23;
      endcase
      tick(2);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      par  = (^d) ^ ($urandom_range(0, 4) == 0);
      send(d, par, stop, $urandom_range(6, 30));
      check_state("rnd");
      if ($urandom_range(0, 1) == 1) read_pulse();
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    // Reset asserted in the middle of a frame.
    baud_div = 16'd16;
    d = 8'h3C;
    send(d, ^d, 1'b1, 8);
    rx = 1'b0;
    tick(3 * 16);
    rst = 1'b0;
    tick(2);
    exp_valid = 0; exp_ovr = 0; exp_ferr = 0; exp_perr = 0; exp_data = 8'h00;
    check_state("mid_rst");
    rx = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(40);
    check_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
